// File: rtl/bat_amateur_microsequencer.sv
// BatAmateur microcode sequencer: ROM indexed by {opcode, step}, all state updated on the falling clock edge.
// Optional single-step mode via `BAT_USEQ_SINGLE_STEP_EN (adds STEP_REQ); the microcode image is supplied through UCODE_INIT.
module bat_amateur_microsequencer #(
    parameter int OPCODE_W    = 6,
    parameter int UOP_W       = 3,
    parameter int CTRL_W      = 32,
    parameter int NUM_FLAGS   = 2,
    parameter int FETCH_STEPS = 2,
    parameter logic [(2**(OPCODE_W+UOP_W))*(CTRL_W+$clog2(NUM_FLAGS+1)+5)-1:0] UCODE_INIT = '0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [OPCODE_W-1:0]  INSTR,
    input  logic [NUM_FLAGS-1:0] FLAGS_IN,
    input  logic                 STALL,
    input  logic                 RESUME,
`ifdef BAT_USEQ_SINGLE_STEP_EN
    input  logic                 STEP_REQ,
`endif
    output logic [CTRL_W-1:0]    CTRL,
    output logic [UOP_W-1:0]     STEP,
    output logic [NUM_FLAGS-1:0] FLAGS,
    output logic                 HALTED,
    output logic                 UOP_OVF
);

    localparam int SEL_W       = $clog2(NUM_FLAGS + 1);
    localparam int WORD_W      = CTRL_W + SEL_W + 5;
    localparam int DEPTH       = 2 ** (OPCODE_W + UOP_W);
    localparam int FLAGS_EXT_W = 2 ** SEL_W;

    typedef enum logic {ST_RUN, ST_HALTED} state_t;

    state_t                   r_state, w_stateNext;
    logic [UOP_W-1:0]         r_step, w_stepNext;
    logic [NUM_FLAGS-1:0]     r_flags, w_flagsNext;
    logic                     r_ovf, w_ovfNext;

    logic [WORD_W-1:0]        w_rom [DEPTH];
    logic [WORD_W-1:0]        w_word;
    logic [OPCODE_W+UOP_W-1:0] w_addr;
    logic                     w_fetch;
    logic [SEL_W-1:0]         w_condSel;
    logic                     w_condInv, w_condEn, w_halt, w_latch, w_end;
    logic [CTRL_W-1:0]        w_ctrl;
    logic [FLAGS_EXT_W-1:0]   w_flagsExt;
    logic                     w_cond, w_skip, w_go;

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        assign w_rom[g] = UCODE_INIT[g*WORD_W +: WORD_W];
    end

    // The first FETCH_STEPS steps of every instruction share opcode 0's row.
    assign w_fetch = ({1'b0, r_step} < (UOP_W+1)'(FETCH_STEPS));
    assign w_addr  = {w_fetch ? {OPCODE_W{1'b0}} : INSTR, r_step};
    assign w_word  = w_rom[w_addr];
    assign {w_condSel, w_condInv, w_condEn, w_halt, w_latch, w_end, w_ctrl} = w_word;

    // Zero-extended so that selector values beyond the real flags read as 0.
    assign w_flagsExt = FLAGS_EXT_W'(r_flags);
    assign w_cond     = w_flagsExt[w_condSel] ^ w_condInv;
    assign w_skip     = w_condEn & ~w_cond;

`ifdef BAT_USEQ_SINGLE_STEP_EN
    assign w_go = STEP_REQ;
`else
    assign w_go = 1'b1;
`endif

    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_RUN;
            r_step  <= '0;
            r_flags <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_step  <= w_stepNext;
            r_flags <= w_flagsNext;
            r_ovf   <= w_ovfNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_stepNext  = r_step;
        w_flagsNext = r_flags;
        w_ovfNext   = r_ovf;
        CTRL        = '0;
        case (r_state)
            ST_RUN: begin
                if (!RST && w_go && !w_skip) begin
                    CTRL = w_ctrl;
                end
                // A stall freezes everything but keeps CTRL driven so the memory access is held.
                if (!STALL && w_go) begin
                    if (w_latch && !w_skip) begin
                        w_flagsNext = FLAGS_IN;
                    end
                    if (w_halt && !w_skip) begin
                        w_stateNext = ST_HALTED;
                        w_stepNext  = '0;
                    end else if (w_end || w_skip) begin
                        w_stepNext = '0;
                    end else if (r_step == {UOP_W{1'b1}}) begin
                        w_stepNext = '0;
                        w_ovfNext  = 1'b1;
                    end else begin
                        w_stepNext = r_step + 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                if (RESUME) begin
                    w_stateNext = ST_RUN;
                    w_stepNext  = '0;
                end
            end
            default: begin
                w_stateNext = ST_RUN;
            end
        endcase
    end

    assign STEP    = r_step;
    assign FLAGS   = r_flags;
    assign HALTED  = (r_state == ST_HALTED);
    assign UOP_OVF = r_ovf;

endmodule
